// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver state encoding
package uart_pkg;

  localparam logic [11:0] BAUD_DEFAULT = 12'hA2C;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  function automatic logic [11:0] half_bit(input logic [11:0] baud);
    return {1'b0, baud[11:1]};
  endfunction

endpackage

// File: rtl/rx_sync.sv
// rtl/rx_sync.sv - two-flop RX synchroniser plus edge flop, preset to idle-high
module rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic rx_ff1;
  logic rx_ff2;
  logic rx_ff3;

  // Preset to 1 so leaving reset never looks like a falling start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ff1 <= 1'b1;
      rx_ff2 <= 1'b1;
      rx_ff3 <= 1'b1;
    end else begin
      rx_ff1 <= rx;
      rx_ff2 <= rx_ff1;
      rx_ff3 <= rx_ff2;
    end
  end

  assign rx_s = rx_ff2;
  assign fall = rx_ff3 & ~rx_ff2;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with centre sampling, rdy handshake and framing flag
module uart_rx
  import uart_pkg::*;
#(
  parameter logic [11:0] BAUD = BAUD_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err
);

  // Counters run N-1..0, so one bit spans exactly BAUD clocks.
  localparam logic [11:0] HALF_LOAD = half_bit(BAUD) - 12'd1;
  localparam logic [11:0] BIT_LOAD  = BAUD - 12'd1;

  rx_state_t   state;
  logic [11:0] baud_cnt;
  logic [3:0]  bit_cnt;
  logic [7:0]  shift_reg;
  logic        rx_s;
  logic        fall;
  logic        baud_zero;

  rx_sync u_rx_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .rx   (RX),
    .rx_s (rx_s),
    .fall (fall)
  );

  assign baud_zero = (baud_cnt == 12'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      baud_cnt  <= 12'd0;
      bit_cnt   <= 4'd0;
      shift_reg <= 8'h00;
      rx_data   <= 8'h00;
      rdy       <= 1'b0;
      frm_err   <= 1'b0;
    end else begin
      if (clr_rdy) rdy <= 1'b0;
      case (state)
        IDLE: begin
          if (fall) begin
            state    <= START;
            baud_cnt <= HALF_LOAD;
            bit_cnt  <= 4'd0;
            rdy      <= 1'b0;
          end
        end
        START: begin
          if (baud_zero) begin
            // A high line at start-bit centre was a glitch.
            if (rx_s) begin
              state <= IDLE;
            end else begin
              state    <= DATA;
              baud_cnt <= BIT_LOAD;
            end
          end else begin
            baud_cnt <= baud_cnt - 12'd1;
          end
        end
        DATA: begin
          if (baud_zero) begin
            shift_reg <= {rx_s, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 4'd1;
            baud_cnt  <= BIT_LOAD;
            if (bit_cnt == 4'd7) state <= STOP;
          end else begin
            baud_cnt <= baud_cnt - 12'd1;
          end
        end
        STOP: begin
          // Completion overrides a same-cycle clr_rdy.
          if (baud_zero) begin
            rx_data <= shift_reg;
            frm_err <= ~rx_s;
            rdy     <= 1'b1;
            state   <= IDLE;
          end else begin
            baud_cnt <= baud_cnt - 12'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx against a frame-timing model
module tb_uart_rx;

  localparam int B = 32;
  localparam int H = B / 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;

  int vectors = 0;
  int miscompares = 0;

  int cyc = 0;
  logic wave [0:65535];
  logic clrw [0:65535];

  logic       m_active = 1'b0;
  int         m_f = 0;
  int         m_rst_cyc = 0;
  logic       m_rdy = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       m_err = 1'b0;
  logic       m_started;
  logic       m_set;

  logic       rdy_q = 1'b0;
  int         rise_cyc = 0;
  logic [7:0] got_q [$];

  uart_rx #(.BAUD(12'd32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .RX     (rx),
    .clr_rdy(clr_rdy),
    .rx_data(rx_data),
    .rdy    (rdy),
    .frm_err(frm_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: line value wave[n] is present during cycle n; a fall at n
  // is seen 3 edges later, bit k sampled at wave[n+H+k*B], rdy after edge n+3+H+9B.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active  = 1'b0;
      m_rdy     = 1'b0;
      m_data    = 8'h00;
      m_err     = 1'b0;
      m_rst_cyc = cyc;
    end else begin
      cyc++;
      m_started = 1'b0;
      m_set     = 1'b0;
      if (m_active && cyc == m_f + 3 + H) begin
        if (wave[m_f + H]) m_active = 1'b0;
      end else if (m_active && cyc == m_f + 3 + H + 9 * B) begin
        for (int k = 0; k < 8; k++) m_data[k] = wave[m_f + H + (k + 1) * B];
        m_err    = !wave[m_f + H + 9 * B];
        m_set    = 1'b1;
        m_active = 1'b0;
      end else if (!m_active && cyc - 4 >= m_rst_cyc && wave[cyc - 4] && !wave[cyc - 3]) begin
        m_active  = 1'b1;
        m_f       = cyc - 3;
        m_started = 1'b1;
      end
      if (m_set) m_rdy = 1'b1;
      else if (m_started || clrw[cyc - 1]) m_rdy = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      rdy_q = 1'b0;
    end else if (cyc > 0) begin
      check("rdy", {31'd0, rdy}, {31'd0, m_rdy});
      check("rx_data", {24'd0, rx_data}, {24'd0, m_data});
      if (m_rdy) check("frm_err", {31'd0, frm_err}, {31'd0, m_err});
      if (rdy && !rdy_q) begin
        rise_cyc = cyc;
        got_q.push_back(rx_data);
      end
      rdy_q = rdy;
    end
  end

  task automatic step(input logic rv, input logic cv);
    @(posedge clk);
    #1;
    rx      = rv;
    clr_rdy = cv;
    wave[cyc] = rv;
    clrw[cyc] = cv;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'b0);
  endtask

  task automatic send(input logic [7:0] d, input logic stop_v, input int clr_at,
                      input int limit, output int f);
    logic [9:0] fr;
    int n;
    fr = {stop_v, d, 1'b0};
    n  = 0;
    f  = 0;
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < B; j++) begin
        if (n < limit) begin
          step(fr[k], n == clr_at);
          if (n == 0) f = cyc;
        end
        n++;
      end
    end
  endtask

  initial begin
    #2000000;
    miscompares++;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    int f;
    int kind;
    int gap;
    int lo;
    int clr_at;
    logic [7:0] d;
    for (int i = 0; i < 65536; i++) begin
      wave[i] = 1'b1;
      clrw[i] = 1'b0;
    end
    rst_n   = 1'b0;
    rx      = 1'b1;
    clr_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rdy", {31'd0, rdy}, 32'd0);
    check("reset_rx_data", {24'd0, rx_data}, 32'h00);
    check("reset_frm_err", {31'd0, frm_err}, 32'd0);
    rst_n = 1'b1;
    idle(6);

    // Single frame: latency = 2 sync + H + 9*B (+1 edge to observe) = 307.
    send(8'h6A, 1'b1, -1, 1000, f);
    check("t1_latency", rise_cyc - f, 32'd307);
    check("t1_data", {24'd0, rx_data}, 32'h6A);
    check("t1_frm_err", {31'd0, frm_err}, 32'd0);

    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    check("t2_clr", {31'd0, rdy}, 32'd0);
    check("t2_data_kept", {24'd0, rx_data}, 32'h6A);
    idle(4);
    send(8'h5C, 1'b1, 2 + H + 9 * B, 1000, f);
    check("t2_set_wins", {31'd0, rdy}, 32'd1);
    check("t2_data", {24'd0, rx_data}, 32'h5C);

    got_q.delete();
    send(8'hA5, 1'b1, -1, 1000, f);
    send(8'h00, 1'b1, -1, 1000, f);
    check("t3_count", got_q.size(), 32'd2);
    if (got_q.size() == 2) begin
      check("t3_first", {24'd0, got_q[0]}, 32'hA5);
      check("t3_second", {24'd0, got_q[1]}, 32'h00);
    end

    repeat (8) step(1'b0, 1'b0);
    idle(40);
    check("t4_glitch_rdy", {31'd0, rdy}, 32'd0);
    check("t4_data_kept", {24'd0, rx_data}, 32'h00);

    send(8'hFF, 1'b0, -1, 1000, f);
    check("t5_rdy", {31'd0, rdy}, 32'd1);
    check("t5_data", {24'd0, rx_data}, 32'hFF);
    check("t5_frm_err", {31'd0, frm_err}, 32'd1);
    repeat (100) step(1'b0, 1'b0);
    check("t5_break_hold", {31'd0, rdy}, 32'd1);
    idle(5);

    send(8'h3C, 1'b1, -1, H + 3 * B, f);
    #3;
    rst_n = 1'b0;
    rx    = 1'b1;
    #1;
    check("t6_reset_rdy", {31'd0, rdy}, 32'd0);
    check("t6_reset_data", {24'd0, rx_data}, 32'h00);
    repeat (3) step(1'b1, 1'b0);
    rst_n = 1'b1;
    idle(6);
    send(8'h3C, 1'b1, -1, 1000, f);
    check("t6_data", {24'd0, rx_data}, 32'h3C);
    check("t6_rdy", {31'd0, rdy}, 32'd1);
    idle(3);

    for (int r = 0; r < 30; r++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        lo = $urandom_range(1, H - 1);
        repeat (lo) step(1'b0, 1'b0);
        idle(H + 8);
      end else begin
        d      = 8'($urandom);
        clr_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 10 * B - 1) : -1;
        send(d, kind != 1, clr_at, 1000, f);
        gap = $urandom_range(0, 12);
        for (int g = 0; g < gap; g++) step(1'b1, $urandom_range(0, 3) == 0);
      end
    end
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
